// File: rtl/axis_ep_rx.sv
// AXI4 write-slave endpoint for the inter-FPGA stream write protocol.
// Data bursts pass through to AXI-stream, control words go to a message port, and B responses are queued.
module axis_ep_rx #(
    parameter int ID_W    = 16,
    parameter int DATA_W  = 512,
    parameter int B_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [63:0]       s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [ID_W-1:0]   s_awid,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [4:0]        m_tid,
    output logic              m_tlast,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [18:0]       c_msg
);

    localparam int BQ_AW = $clog2(B_DEPTH);
    localparam logic [BQ_AW:0] BQ_FULL = (BQ_AW + 1)'(B_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, CTRL} state_t;

    state_t            state, state_next;
    logic [11:0]       addr_q;
    logic [7:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        beat_cnt;
    logic              err_q;
    logic              aw_fire, w_fire, burst_end, beat_err, resp_bad;
    logic [6:0]        win_end;
    logic [ID_W+1:0]   bq_mem [B_DEPTH];
    logic [BQ_AW-1:0]  bq_wr, bq_rd;
    logic [BQ_AW:0]    bq_cnt;
    logic              bq_push, bq_pop;
    logic              unused_addr;

    assign unused_addr = ^{s_awaddr[63:19], s_awaddr[5:0]};

    always_comb begin
        state_next = state;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        m_tvalid   = 1'b0;
        c_valid    = 1'b0;
        case (state)
            IDLE: begin
                s_awready = !rst && (bq_cnt < BQ_FULL);
                if (s_awvalid && !rst && (bq_cnt < BQ_FULL))
                    state_next = s_awaddr[18] ? CTRL : DATA;
            end
            DATA: begin
                m_tvalid = s_wvalid;
                s_wready = m_tready;
                if (s_wvalid && m_tready && s_wlast)
                    state_next = IDLE;
            end
            CTRL: begin
                // Only the first beat carries the message; extra beats are swallowed
                if (beat_cnt == 8'd0) begin
                    c_valid  = s_wvalid;
                    s_wready = c_ready;
                end else begin
                    s_wready = 1'b1;
                end
                if (s_wvalid && s_wready && s_wlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign aw_fire   = s_awvalid && s_awready;
    assign w_fire    = s_wvalid && s_wready;
    assign burst_end = w_fire && s_wlast;
    assign beat_err  = w_fire && ((state == CTRL && beat_cnt != 8'd0) ||
                                  (!s_wlast && beat_cnt == len_q));
    assign resp_bad  = err_q || beat_err || (beat_cnt != len_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else if (aw_fire) begin
            addr_q   <= s_awaddr[17:6];
            len_q    <= s_awlen;
            id_q     <= s_awid;
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_err) err_q <= 1'b1;
        end
    end

    // Window end is the 7-bit wrapped line index of the burst's final beat
    assign win_end = addr_q[6:0] + len_q[6:0];
    assign m_tdata = s_wdata;
    assign m_tid   = addr_q[11:7];
    assign m_tlast = s_wlast && (win_end == 7'h7F);
    assign c_msg   = {s_wdata[13], s_wdata[12:7], s_wdata[6], s_wdata[5:0], addr_q[4:0]};

    assign bq_push = burst_end;
    assign bq_pop  = s_bvalid && s_bready;

    always_ff @(posedge clk) begin
        if (bq_push) bq_mem[bq_wr] <= {id_q, resp_bad ? 2'b10 : 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bq_wr  <= '0;
            bq_rd  <= '0;
            bq_cnt <= '0;
        end else begin
            if (bq_push) bq_wr <= bq_wr + 1'b1;
            if (bq_pop)  bq_rd <= bq_rd + 1'b1;
            case ({bq_push, bq_pop})
                2'b10:   bq_cnt <= bq_cnt + 1'b1;
                2'b01:   bq_cnt <= bq_cnt - 1'b1;
                default: bq_cnt <= bq_cnt;
            endcase
        end
    end

    assign s_bvalid = (bq_cnt != '0);
    assign s_bid    = s_bvalid ? bq_mem[bq_rd][ID_W+1:2] : '0;
    assign s_bresp  = s_bvalid ? bq_mem[bq_rd][1:0] : 2'b00;

endmodule

// File: tb/tb_axis_ep_rx.sv
// Self-checking bench for axis_ep_rx: directed protocol cases plus randomized bursts
// checked against a transaction-level model of stream beats, control messages and B responses.
module tb_axis_ep_rx;

    typedef struct {
        logic [4:0]   tid;
        logic         tlast;
        logic [511:0] data;
    } beat_t;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  resp;
    } bresp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_awvalid, s_awready;
    logic [63:0]  s_awaddr;
    logic [7:0]   s_awlen;
    logic [15:0]  s_awid;
    logic         s_wvalid, s_wready;
    logic [511:0] s_wdata;
    logic         s_wlast;
    logic         s_bvalid, s_bready;
    logic [15:0]  s_bid;
    logic [1:0]   s_bresp;
    logic         m_tvalid, m_tready;
    logic [511:0] m_tdata;
    logic [4:0]   m_tid;
    logic         m_tlast;
    logic         c_valid, c_ready;
    logic [18:0]  c_msg;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_stall = 1'b0;

    beat_t        exp_beats[$], got_beats[$];
    logic [18:0]  exp_ctrl[$],  got_ctrl[$];
    bresp_t       exp_b[$],     got_b[$];
    logic [511:0] wbuf [0:79];

    axis_ep_rx #(.ID_W(16), .DATA_W(512), .B_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tid(m_tid), .m_tlast(m_tlast),
        .c_valid(c_valid), .c_ready(c_ready), .c_msg(c_msg)
    );

    always #5 clk = ~clk;

    // Handshakes are recorded at the negedge before the edge on which they complete
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) got_beats.push_back('{m_tid, m_tlast, m_tdata});
            if (c_valid && c_ready)   got_ctrl.push_back(c_msg);
            if (s_bvalid && s_bready) got_b.push_back('{s_bid, s_bresp});
        end
    end

    task automatic check_output(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_data(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 16; k++)
                wbuf[i][k*32 +: 32] = $urandom;
    endtask

    // Transaction-level model: what a burst must produce on each output port
    task automatic model_burst(input logic [63:0] addr, input int len, input int nbeats, input logic [15:0] id);
        longint line, tid, v, msg;
        bresp_t b;
        b.id = id;
        if (((addr >> 18) % 2) == 1) begin
            v   = longint'(wbuf[0][13:0]);
            msg = (((v >> 13) % 2) << 18) | (((v >> 7) % 64) << 12) | (((v >> 6) % 2) << 11)
                | ((v % 64) << 5) | longint'((addr >> 6) % 32);
            exp_ctrl.push_back(19'(msg));
            b.resp = (nbeats == 1 && len == 0) ? 2'b00 : 2'b10;
        end else begin
            tid  = longint'((addr >> 13) % 32);
            line = longint'((addr >> 6) % 128);
            for (int i = 0; i < nbeats; i++)
                exp_beats.push_back('{5'(tid), (i == nbeats - 1) && ((line + len) % 128 == 127), wbuf[i]});
            b.resp = (nbeats == len + 1) ? 2'b00 : 2'b10;
        end
        exp_b.push_back(b);
    endtask

    task automatic drive_aw(input logic [63:0] addr, input int len, input logic [15:0] id);
        bit ok = 1'b0;
        s_awvalid = 1'b1;
        s_awaddr  = addr;
        s_awlen   = 8'(len);
        s_awid    = id;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (s_awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        check_output("aw_accept", 576'(ok), 576'(1));
    endtask

    task automatic drive_beat(input int i, input bit last);
        bit ok = 1'b0;
        int hold;
        if (rand_stall && ($urandom % 4 == 0)) begin
            @(posedge clk); #1;
        end
        hold = rand_stall ? int'($urandom % 3) : 0;
        if (hold > 0) begin
            m_tready = 1'b0;
            c_ready  = 1'b0;
        end
        s_wvalid = 1'b1;
        s_wdata  = wbuf[i];
        s_wlast  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_wready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (hold > 0) hold--;
            if (hold == 0) begin
                m_tready = 1'b1;
                c_ready  = 1'b1;
            end
        end
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        m_tready = 1'b1;
        c_ready  = 1'b1;
        check_output("w_accept", 576'(ok), 576'(1));
    endtask

    task automatic wait_b(input int n);
        for (int t = 0; t < 100; t++) begin
            if (got_b.size() >= n) break;
            @(posedge clk); #1;
        end
        check_output("b_arrive", 576'(got_b.size() >= n), 576'(1));
    endtask

    task automatic compare_all();
        check_output("stream_count", 576'(got_beats.size()), 576'(exp_beats.size()));
        check_output("ctrl_count", 576'(got_ctrl.size()), 576'(exp_ctrl.size()));
        check_output("b_count", 576'(got_b.size()), 576'(exp_b.size()));
        for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++)
            check_output("stream_beat", 576'({got_beats[i].tid, got_beats[i].tlast, got_beats[i].data}),
                                        576'({exp_beats[i].tid, exp_beats[i].tlast, exp_beats[i].data}));
        for (int i = 0; i < got_ctrl.size() && i < exp_ctrl.size(); i++)
            check_output("ctrl_msg", 576'(got_ctrl[i]), 576'(exp_ctrl[i]));
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
            check_output("b_resp", 576'({got_b[i].id, got_b[i].resp}), 576'({exp_b[i].id, exp_b[i].resp}));
        got_beats.delete(); exp_beats.delete();
        got_ctrl.delete();  exp_ctrl.delete();
        got_b.delete();     exp_b.delete();
    endtask

    task automatic apply_stimulus(input logic [63:0] addr, input int len, input int nbeats, input logic [15:0] id);
        model_burst(addr, len, nbeats, id);
        drive_aw(addr, len, id);
        for (int i = 0; i < nbeats; i++) drive_beat(i, i == nbeats - 1);
        wait_b(exp_b.size());
        compare_all();
    endtask

    initial begin
        int stall_hits;
        logic [63:0] a;
        int len, nb;

        rst = 1'b1;
        s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wlast = 1'b0;
        s_bready = 1'b1; m_tready = 1'b1; c_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_outputs", 576'({s_awready, s_wready, s_bvalid, m_tvalid, c_valid}), 576'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_awready", 576'(s_awready), 576'(1));
        @(posedge clk); #1;

        // Window-ending data burst
        fill_data(4);
        apply_stimulus(64'h2000 | (64'(7'h7F - 3) << 6), 3, 4, 16'h0011);

        // Full 64-beat burst that never reaches the window end
        fill_data(64);
        apply_stimulus(64'h0, 63, 64, 16'hBEEF);

        // Control write
        fill_data(1);
        wbuf[0][13:0] = 14'h2A45;
        apply_stimulus(64'h40000 | (64'd5 << 6), 0, 1, 16'h0C0C);

        // Early wlast, then a clean burst
        fill_data(2);
        apply_stimulus(64'h4000, 3, 2, 16'h0002);
        fill_data(2);
        apply_stimulus(64'h6040, 1, 2, 16'h0003);

        // B queue full withholds awready until one response drains
        s_bready = 1'b0;
        fill_data(2);
        model_burst(64'h0080, 1, 2, 16'h00A1);
        drive_aw(64'h0080, 1, 16'h00A1);
        drive_beat(0, 1'b0); drive_beat(1, 1'b1);
        fill_data(1);
        model_burst(64'h40000, 0, 1, 16'h00A2);
        drive_aw(64'h40000, 0, 16'h00A2);
        drive_beat(0, 1'b1);
        fill_data(3);
        model_burst(64'h8000, 2, 3, 16'h00A3);
        s_awvalid = 1'b1; s_awaddr = 64'h8000; s_awlen = 8'd2; s_awid = 16'h00A3;
        stall_hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_awready) stall_hits++;
        end
        check_output("aw_stall_full", 576'(stall_hits), 576'(0));
        @(posedge clk); #1;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        drive_aw(64'h8000, 2, 16'h00A3);
        for (int i = 0; i < 3; i++) drive_beat(i, i == 2);
        s_bready = 1'b1;
        wait_b(3);
        compare_all();

        // Ten-cycle stream stall in mid-burst
        fill_data(4);
        model_burst(64'h1_2340, 3, 4, 16'h0055);
        drive_aw(64'h1_2340, 3, 16'h0055);
        drive_beat(0, 1'b0);
        m_tready = 1'b0;
        s_wvalid = 1'b1; s_wdata = wbuf[1]; s_wlast = 1'b0;
        stall_hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_wready !== 1'b0) stall_hits++;
        end
        check_output("wready_stall", 576'(stall_hits), 576'(0));
        @(posedge clk); #1;
        m_tready = 1'b1;
        drive_beat(1, 1'b0); drive_beat(2, 1'b0); drive_beat(3, 1'b1);
        wait_b(1);
        compare_all();

        // Randomized bursts with bubbles, backpressure and occasional length errors
        rand_stall = 1'b1;
        for (int n = 0; n < 24; n++) begin
            a   = {$urandom, $urandom};
            len = int'($urandom % 16);
            nb  = ($urandom % 5 == 0) ? int'($urandom_range(1, len + 3)) : len + 1;
            if ($urandom % 3 == 0) a[18] = 1'b1;
            else                   a[18] = 1'b0;
            fill_data(nb);
            apply_stimulus(a, len, nb, 16'($urandom));
        end
        rand_stall = 1'b0;

        // Reset in mid-burst drops the burst and any queued responses
        s_bready = 1'b0;
        fill_data(8);
        drive_aw(64'h0100, 0, 16'h0F0F);
        drive_beat(0, 1'b1);
        drive_aw(64'h0200, 7, 16'h0E0E);
        drive_beat(0, 1'b0); drive_beat(1, 1'b0);
        s_wvalid = 1'b1; s_wdata = wbuf[2]; s_wlast = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("rst_mid_valids", 576'({m_tvalid, c_valid, s_bvalid, s_awready}), 576'(0));
        s_wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        s_bready = 1'b1;
        got_beats.delete(); got_ctrl.delete(); got_b.delete();
        exp_beats.delete(); exp_ctrl.delete(); exp_b.delete();
        fill_data(2);
        apply_stimulus(64'h0300, 1, 2, 16'h0D0D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
